// File: rtl/gesture_uart_tx_if.sv
// gesture_uart_tx_if: classifier-side input and serial-side outputs of the
// gesture UART transmitter.
interface gesture_uart_tx_if;
    logic [7:0] gesture_data;
    logic [7:0] stable_gesture;
    logic       uart_tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (output gesture_data, input stable_gesture, uart_tx, tx_busy, tx_done);
    modport slave  (input gesture_data, output stable_gesture, uart_tx, tx_busy, tx_done);
endinterface

// File: rtl/gesture_uart_tx.sv
// gesture_uart_tx: debounces the classifier's gesture code and sends each newly
// accepted code, plus periodic keep-alive repeats, as an 8N1 UART frame.
//
// state | meaning
// IDLE  | line high, waiting for a pending request
// START | start bit, line low
// DATA  | eight data bits, LSB first
// STOP  | stop bit, line high; tx_done on its last cycle
module gesture_uart_tx #(
    parameter int CLKS_PER_BIT  = 104,
    parameter int STABLE_CYCLES = 120000,
    parameter int REPEAT_CYCLES = 1200000
) (
    input  logic             clk,
    input  logic             r_rstn,
    gesture_uart_tx_if.slave bus
);
    localparam int BIT_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam int REP_W  = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [BIT_W-1:0]  BIT_LOAD  = BIT_W'(CLKS_PER_BIT - 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(STABLE_CYCLES);
    localparam logic [REP_W-1:0]  REP_LOAD  = REP_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam bit                REP_EN    = (REPEAT_CYCLES > 0);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_nxt;
    logic [7:0]        candidate;
    logic [STAB_W-1:0] stab_cnt;
    logic [7:0]        stable_q;
    logic              pend;
    logic [7:0]        pend_byte;
    logic [7:0]        shift_reg;
    logic [BIT_W-1:0]  bit_tmr;
    logic [2:0]        bit_idx;
    logic [REP_W-1:0]  rep_tmr;

    logic same, qualify, accept, bit_tc, launch, rep_run, rep_fire;
    logic uart_tx_c, tx_busy_c, tx_done_c;

    assign same    = (bus.gesture_data == candidate);
    // With a one-sample window the first differing sample already qualifies.
    assign qualify = same ? (stab_cnt == STAB_LAST) : (STABLE_CYCLES == 1);
    assign accept  = qualify && (bus.gesture_data != 8'h00) && (bus.gesture_data != stable_q);
    assign bit_tc  = (bit_tmr == '0);
    assign launch  = pend && ((state == IDLE) || ((state == STOP) && bit_tc));
    assign rep_run  = REP_EN && (state == IDLE) && !pend && (stable_q != 8'h00);
    assign rep_fire = rep_run && (rep_tmr == '0);

    always_ff @(posedge clk) begin
        if (!r_rstn) begin
            candidate <= 8'h00;
            stab_cnt  <= '0;
            stable_q  <= 8'h00;
        end else begin
            if (!same) begin
                candidate <= bus.gesture_data;
                stab_cnt  <= STAB_W'(1);
            end else if (stab_cnt != STAB_MAX) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
            if (qualify)
                stable_q <= bus.gesture_data;
        end
    end

    // Launch consumes the old request first, so a same-cycle acceptance
    // stays pending for the next frame instead of touching shift_reg.
    always_ff @(posedge clk) begin
        if (!r_rstn) begin
            pend      <= 1'b0;
            pend_byte <= 8'h00;
            shift_reg <= 8'h00;
            rep_tmr   <= REP_LOAD;
        end else begin
            if (launch) begin
                shift_reg <= pend_byte;
                pend      <= 1'b0;
            end
            if (accept) begin
                pend      <= 1'b1;
                pend_byte <= bus.gesture_data;
            end else if (rep_fire) begin
                pend      <= 1'b1;
                pend_byte <= stable_q;
            end
            if (launch || accept || rep_fire)
                rep_tmr <= REP_LOAD;
            else if (rep_run)
                rep_tmr <= rep_tmr - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!r_rstn) begin
            bit_tmr <= BIT_LOAD;
            bit_idx <= 3'd0;
        end else begin
            if (launch || ((state != IDLE) && bit_tc))
                bit_tmr <= BIT_LOAD;
            else if (state != IDLE)
                bit_tmr <= bit_tmr - 1'b1;
            if (state == START)
                bit_idx <= 3'd0;
            else if ((state == DATA) && bit_tc)
                bit_idx <= bit_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!r_rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pend) state_nxt = START;
            START:   if (bit_tc) state_nxt = DATA;
            DATA:    if (bit_tc && (bit_idx == 3'd7)) state_nxt = STOP;
            STOP:    if (bit_tc) state_nxt = pend ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        uart_tx_c = 1'b1;
        tx_busy_c = 1'b0;
        tx_done_c = 1'b0;
        case (state)
            START: begin
                uart_tx_c = 1'b0;
                tx_busy_c = 1'b1;
            end
            DATA: begin
                uart_tx_c = shift_reg[bit_idx];
                tx_busy_c = 1'b1;
            end
            STOP: begin
                tx_busy_c = 1'b1;
                tx_done_c = bit_tc;
            end
            default: ;
        endcase
    end

    assign bus.uart_tx        = uart_tx_c;
    assign bus.tx_busy        = tx_busy_c;
    assign bus.tx_done        = tx_done_c;
    assign bus.stable_gesture = stable_q;
endmodule

// File: tb/tb_gesture_uart_tx.sv
// tb_gesture_uart_tx: directed gesture scenarios followed by random gesture
// sequences, compared cycle by cycle against a frame-position reference model.
module tb_gesture_uart_tx;
    localparam int CPB    = 4;
    localparam int STABLE = 8;
    localparam int REPEAT = 200;
    localparam int FRAME  = 10 * CPB;

    logic clk = 1'b0;
    logic r_rstn;
    gesture_uart_tx_if bus ();

    gesture_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .STABLE_CYCLES(STABLE),
        .REPEAT_CYCLES(REPEAT)
    ) dut (
        .clk   (clk),
        .r_rstn(r_rstn),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cycle = 0;

    // Reference model: a frame is described only by its start and its byte;
    // the line value follows from the position inside the frame.
    logic [7:0] m_cand, m_stable, m_pend_byte, m_byte;
    int         m_cnt, m_rep, m_pos;
    bit         m_pend, m_active;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cycle, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        m_cand = 8'h00; m_stable = 8'h00; m_pend_byte = 8'h00; m_byte = 8'h00;
        m_cnt = 0; m_rep = 0; m_pos = 0; m_pend = 0; m_active = 0;
    endtask

    task automatic model_step(input logic [7:0] gd, input logic rstn);
        bit         fire, acc, ending, idle, launch, rep_fire;
        logic [7:0] old_stable;
        bit         old_pend;
        logic [7:0] old_pb;
        if (!rstn) begin
            model_reset();
            return;
        end
        old_stable = m_stable;
        old_pend   = m_pend;
        old_pb     = m_pend_byte;
        fire = 0;
        if (gd != m_cand) begin
            m_cand = gd;
            m_cnt  = 1;
            fire   = (STABLE == 1);
        end else if (m_cnt < STABLE) begin
            m_cnt++;
            fire = (m_cnt == STABLE);
        end
        acc = fire && (gd != 8'h00) && (gd != old_stable);
        if (fire) m_stable = gd;

        idle     = !m_active;
        ending   = m_active && (m_pos == FRAME - 1);
        launch   = old_pend && (idle || ending);
        rep_fire = (REPEAT > 0) && idle && !old_pend && (old_stable != 8'h00) && (m_rep == REPEAT - 1);

        if (launch || acc || rep_fire) m_rep = 0;
        else if (idle && !old_pend && old_stable != 8'h00) m_rep++;

        if (launch) begin
            m_active = 1; m_pos = 0; m_byte = old_pb;
        end else if (m_active) begin
            if (ending) m_active = 0;
            else m_pos++;
        end

        if (launch) m_pend = 0;
        if (acc) begin
            m_pend = 1; m_pend_byte = gd;
        end else if (rep_fire) begin
            m_pend = 1; m_pend_byte = old_stable;
        end
    endtask

    function automatic logic exp_line();
        int slot;
        if (!m_active) return 1'b1;
        slot = m_pos / CPB;
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return m_byte[slot - 1];
    endfunction

    int done_seen = 0;

    // Drive for one cycle, advance the model across the edge, then check on the falling edge.
    task automatic step(input logic [7:0] gd, input logic rstn);
        bus.gesture_data = gd;
        r_rstn = rstn;
        @(posedge clk);
        model_step(gd, rstn);
        cycle++;
        @(negedge clk);
        check_val("uart_tx", {31'd0, bus.uart_tx}, {31'd0, exp_line()});
        check_val("tx_busy", {31'd0, bus.tx_busy}, {31'd0, m_active});
        check_val("tx_done", {31'd0, bus.tx_done}, {31'd0, (m_active && m_pos == FRAME - 1)});
        check_val("stable_gesture", {24'd0, bus.stable_gesture}, {24'd0, m_stable});
        if (bus.tx_done === 1'b1) done_seen++;
    endtask

    task automatic hold(input logic [7:0] gd, input int n);
        for (int i = 0; i < n; i++) step(gd, 1'b1);
    endtask

    logic [7:0] codes [7] = '{8'h00, 8'h66, 8'h62, 8'h6E, 8'h72, 8'h6C, 8'h3B};

    initial begin
        model_reset();
        bus.gesture_data = 8'h00;
        r_rstn = 1'b0;
        step(8'h00, 1'b0);
        step(8'h00, 1'b0);

        // idle line with no gesture
        done_seen = 0;
        hold(8'h00, 500);
        check_val("no_frame_on_zero", done_seen, 0);

        // single frame of 0x66
        done_seen = 0;
        hold(8'h66, 60);
        check_val("one_frame_66", done_seen, 1);

        // short 0x66 rejected, 0x62 sent once
        hold(8'h00, 20);
        done_seen = 0;
        hold(8'h66, 7);
        hold(8'h62, 60);
        check_val("one_frame_62", done_seen, 1);

        // newer code overwrites pending during a frame
        hold(8'h00, 20);
        done_seen = 0;
        hold(8'h6E, 10);
        hold(8'h72, 10);
        hold(8'h6C, 80);
        check_val("two_frames_6e_6c", done_seen, 2);

        // keep-alive repeats
        hold(8'h3B, 1000);

        // reset during a data bit, then re-qualification
        hold(8'h72, 26);
        step(8'h72, 1'b0);
        hold(8'h72, 100);

        // random gesture sequences with occasional resets
        for (int seg = 0; seg < 120; seg++) begin
            logic [7:0] code;
            int len;
            code = codes[$urandom_range(0, 6)];
            len  = $urandom_range(1, 60);
            if ($urandom_range(0, 29) == 0) begin
                for (int r = 0; r < int'($urandom_range(1, 2)); r++) step(code, 1'b0);
            end
            hold(code, len);
        end
        hold(8'h00, 300);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
